// File: rtl/slow_vram_sched.sv
// Slot scheduler for the slow VRAM: four fixed 4-cycle slots per 16-cycle period
// (sprite even, fix, sprite odd, CPU) with a single queued CPU write.
module slow_vram_sched (
  input  logic        CLK_24M,
  input  logic        RESETP,
  input  logic        SYNC_LOAD,
  input  logic        SPR_EN,
  input  logic [14:0] FIXMAP_ADDR,
  input  logic [14:0] SPRMAP_ADDR,
  input  logic [14:0] VRAM_ADDR,
  input  logic [15:0] VRAM_WRITE,
  input  logic        nVRAM_WRITE_REQ,
  input  logic        REG_VRAMADDR_MSB,
  output logic [14:0] B,
  output logic [15:0] E_OUT,
  output logic        E_OE,
  output logic        nBOE,
  output logic        nBWE,
  output logic        LATCH_SPR_EVEN,
  output logic        LATCH_FIX,
  output logic        LATCH_SPR_ODD,
  output logic        LATCH_CPU,
  output logic        WR_PENDING,
  output logic        WR_DONE
);

  typedef enum logic [1:0] {SlotSprEven, SlotFix, SlotSprOdd, SlotCpu} slot_e;

  logic [3:0]  c_q, c_d;
  logic        run_q;
  logic        prev_req_q;
  logic        req;
  logic        wr_pending_d;
  logic        wr_active_q, wr_active_d;
  logic        fresh_q, fresh_d;
  logic        wr_done_edge;
  logic [14:0] hold_addr_q, act_addr_q, act_addr_d;
  logic [15:0] hold_data_q, act_data_q, act_data_d;
  slot_e       slot;
  logic [1:0]  ph;
  logic        last;
  logic [14:0] b_d;
  logic [15:0] e_out_d;
  logic        e_oe_d, nboe_d, nbwe_d, wr_done_d;
  logic [3:0]  lat_d;

  always_comb begin
    req = prev_req_q & ~nVRAM_WRITE_REQ & ~REG_VRAMADDR_MSB;
    // C is held at 0 across the first live edge so the first post-reset cycle is slot 0.
    c_d = (SYNC_LOAD || !run_q) ? 4'd0 : c_q + 4'd1;
    wr_done_edge = wr_active_q && (c_q == 4'd15);

    wr_active_d = wr_active_q;
    if (c_d == 4'd12) begin
      wr_active_d = WR_PENDING;
    end else if (c_d[3:2] != 2'd3) begin
      wr_active_d = 1'b0;
    end

    // fresh: hold registers carry a request newer than the snapshot being written.
    act_addr_d = act_addr_q;
    act_data_d = act_data_q;
    fresh_d    = fresh_q | req;
    if (c_d == 4'd12) begin
      fresh_d = req;
      if (WR_PENDING) begin
        act_addr_d = hold_addr_q;
        act_data_d = hold_data_q;
      end
    end
    wr_pending_d = wr_done_edge ? (fresh_q | req) : (WR_PENDING | req);
  end

  always_comb begin
    slot      = slot_e'(c_d[3:2]);
    ph        = c_d[1:0];
    last      = (ph == 2'd3);
    b_d       = '0;
    e_out_d   = '0;
    e_oe_d    = 1'b0;
    nboe_d    = 1'b1;
    nbwe_d    = 1'b1;
    lat_d     = '0;
    wr_done_d = 1'b0;
    unique case (slot)
      SlotSprEven: begin
        if (SPR_EN) begin
          b_d      = {SPRMAP_ADDR[14:1], 1'b0};
          nboe_d   = 1'b0;
          lat_d[0] = last;
        end
      end
      SlotFix: begin
        b_d      = FIXMAP_ADDR;
        nboe_d   = 1'b0;
        lat_d[1] = last;
      end
      SlotSprOdd: begin
        if (SPR_EN) begin
          b_d      = {SPRMAP_ADDR[14:1], 1'b1};
          nboe_d   = 1'b0;
          lat_d[2] = last;
        end
      end
      SlotCpu: begin
        if (wr_active_d) begin
          b_d       = act_addr_d;
          e_out_d   = act_data_d;
          e_oe_d    = 1'b1;
          nbwe_d    = !((ph == 2'd1) || (ph == 2'd2));
          wr_done_d = last;
        end else begin
          b_d      = VRAM_ADDR;
          nboe_d   = 1'b0;
          lat_d[3] = last;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      c_q            <= 4'd0;
      run_q          <= 1'b0;
      prev_req_q     <= 1'b1;
      WR_PENDING     <= 1'b0;
      wr_active_q    <= 1'b0;
      fresh_q        <= 1'b0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
      act_addr_q     <= '0;
      act_data_q     <= '0;
      B              <= '0;
      E_OUT          <= '0;
      E_OE           <= 1'b0;
      nBOE           <= 1'b1;
      nBWE           <= 1'b1;
      LATCH_SPR_EVEN <= 1'b0;
      LATCH_FIX      <= 1'b0;
      LATCH_SPR_ODD  <= 1'b0;
      LATCH_CPU      <= 1'b0;
      WR_DONE        <= 1'b0;
    end else begin
      c_q            <= c_d;
      run_q          <= 1'b1;
      prev_req_q     <= nVRAM_WRITE_REQ;
      WR_PENDING     <= wr_pending_d;
      wr_active_q    <= wr_active_d;
      fresh_q        <= fresh_d;
      act_addr_q     <= act_addr_d;
      act_data_q     <= act_data_d;
      if (req) begin
        hold_addr_q <= VRAM_ADDR;
        hold_data_q <= VRAM_WRITE;
      end
      B              <= b_d;
      E_OUT          <= e_out_d;
      E_OE           <= e_oe_d;
      nBOE           <= nboe_d;
      nBWE           <= nbwe_d;
      LATCH_SPR_EVEN <= lat_d[0];
      LATCH_FIX      <= lat_d[1];
      LATCH_SPR_ODD  <= lat_d[2];
      LATCH_CPU      <= lat_d[3];
      WR_DONE        <= wr_done_d;
    end
  end

endmodule

// File: tb/tb_slow_vram_sched.sv
// Scoreboard bench for slow_vram_sched: directed periods push expected strobe/write events,
// a negedge monitor pops and compares them as the DUT raises strobes or WR_DONE.
module tb_slow_vram_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sync_load, spr_en, nreq, msb;
  logic [14:0] fix_addr, spr_addr, vram_addr;
  logic [15:0] vram_wdata;
  logic [14:0] b;
  logic [15:0] e_out;
  logic        e_oe, nboe, nbwe, l_even, l_fix, l_odd, l_cpu, wr_pending, wr_done;

  int   errors = 0;
  int   checks = 0;
  int   tc;
  logic run;
  logic mon_en = 1'b0;

  localparam int KEven = 0, KFix = 1, KOdd = 2, KCpu = 3, KWr = 4;
  typedef struct {int kind; int c; logic [14:0] b; logic [15:0] e;} ev_t;
  ev_t sb[$];

  slow_vram_sched dut (
    .CLK_24M(clk), .RESETP(rst), .SYNC_LOAD(sync_load), .SPR_EN(spr_en),
    .FIXMAP_ADDR(fix_addr), .SPRMAP_ADDR(spr_addr), .VRAM_ADDR(vram_addr),
    .VRAM_WRITE(vram_wdata), .nVRAM_WRITE_REQ(nreq), .REG_VRAMADDR_MSB(msb),
    .B(b), .E_OUT(e_out), .E_OE(e_oe), .nBOE(nboe), .nBWE(nbwe),
    .LATCH_SPR_EVEN(l_even), .LATCH_FIX(l_fix), .LATCH_SPR_ODD(l_odd), .LATCH_CPU(l_cpu),
    .WR_PENDING(wr_pending), .WR_DONE(wr_done)
  );

  // Reference slot counter: first live edge keeps C at 0, SYNC_LOAD reloads 0.
  always @(posedge clk) begin
    if (rst) begin
      tc  <= 0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      tc  <= (!run || sync_load) ? 0 : (tc + 1) % 16;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (C=%0d)", name, act, exp, tc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [14:0] eb, input logic [15:0] ee);
    ev_t x;
    x.kind = kind; x.c = c; x.b = eb; x.e = ee;
    sb.push_back(x);
  endtask

  task automatic push_map_reads();
    push(KEven, 3, 15'h0122, 16'h0);
    push(KFix, 7, 15'h7005, 16'h0);
    push(KOdd, 11, 15'h0123, 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_c(input int k);
    int n = 0;
    do begin
      tick();
      n++;
    end while (tc != k && n < 40);
    if (tc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_c: C=%0d never reached %0d", tc, k);
    end
  endtask

  task automatic request(input logic [14:0] a, input logic [15:0] d);
    nreq = 1'b0;
    vram_addr = a;
    vram_wdata = d;
  endtask

  always @(negedge clk) begin
    logic [4:0] hits;
    ev_t        e;
    int         k;
    if (mon_en) begin
      hits = {wr_done, l_cpu, l_odd, l_fix, l_even};
      chk("invariants", {29'd0, (nbwe == 1'b0 && nboe == 1'b0), (e_oe && !nboe),
                         (!nbwe && !((tc % 4 == 1) || (tc % 4 == 2)))}, 32'd0);
      if (hits != 5'd0) begin
        k = 0;
        for (int i = 0; i < 5; i++) if (hits[i]) k = i;
        chk("single_event", $countones(hits), 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: kind %0d at C=%0d, scoreboard empty", k, tc);
        end else begin
          e = sb.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_c", tc, e.c);
          chk("event_b", {17'd0, b}, {17'd0, e.b});
          if (e.kind == KWr) chk("write_data", {16'd0, e_out}, {16'd0, e.e});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sync_load = 1'b0; spr_en = 1'b1; nreq = 1'b0; msb = 1'b0;
    fix_addr = 15'h7005; spr_addr = 15'h0123; vram_addr = 15'h4000; vram_wdata = 16'h0;
    repeat (3) tick();
    chk("rst_b", {17'd0, b}, 32'd0);
    chk("rst_e_ctl", {13'd0, e_out, e_oe, nboe, nbwe}, {13'd0, 16'h0, 1'b0, 1'b1, 1'b1});
    chk("rst_strobes", {27'd0, l_even, l_fix, l_odd, l_cpu, wr_done}, 32'd0);
    chk("rst_pending", {31'd0, wr_pending}, 32'd0);

    // Period A: read sweep.
    nreq = 1'b1;
    rst = 1'b0;
    mon_en = 1'b1;
    push_map_reads();
    push(KCpu, 15, 15'h4000, 16'h0);
    tick();
    chk("first_c0_nboe", {31'd0, nboe}, 32'd0);
    chk("first_c0_b", {17'd0, b}, 32'h0122);
    wait_c(15);

    // Period B: single write requested at C=2.
    push_map_reads();
    push(KWr, 15, 15'h1234, 16'hBEEF);
    wait_c(2);
    request(15'h1234, 16'hBEEF);
    wait_c(3);
    nreq = 1'b1;
    chk("b_pending", {31'd0, wr_pending}, 32'd1);
    wait_c(12);
    chk("b_c12_bus", {14'd0, b, e_oe, nboe, nbwe}, {14'd0, 15'h1234, 1'b1, 1'b1, 1'b1});
    wait_c(13);
    chk("b_c13_nbwe", {31'd0, nbwe}, 32'd0);
    wait_c(0);
    chk("b_pending_clear", {31'd0, wr_pending}, 32'd0);

    // Period C: two requests, last wins; boundary capture on the C=15 -> 0 edge.
    push_map_reads();
    push(KWr, 15, 15'h0BBB, 16'h2222);
    push_map_reads();
    push(KWr, 15, 15'h0CCC, 16'h3333);
    wait_c(1);
    request(15'h0AAA, 16'h1111);
    wait_c(2);
    nreq = 1'b1;
    wait_c(5);
    request(15'h0BBB, 16'h2222);
    wait_c(6);
    nreq = 1'b1;
    wait_c(15);
    request(15'h0CCC, 16'h3333);
    wait_c(0);
    nreq = 1'b1;
    chk("boundary_pending", {31'd0, wr_pending}, 32'd1);

    // Period D carries the boundary write; SPR_EN drops for period E.
    wait_c(15);
    spr_en = 1'b0;
    push(KFix, 7, 15'h7005, 16'h0);
    push(KCpu, 15, 15'h2345, 16'h0);

    // Period E: fast-VRAM request filtered, sprite slots idle.
    wait_c(0);
    chk("e_pending_clear", {31'd0, wr_pending}, 32'd0);
    chk("e_spr_idle0", {16'd0, b, nboe}, {16'd0, 15'h0, 1'b1});
    wait_c(2);
    msb = 1'b1;
    request(15'h2345, 16'h5555);
    wait_c(3);
    nreq = 1'b1;
    msb = 1'b0;
    wait_c(4);
    chk("fast_vram_ignored", {31'd0, wr_pending}, 32'd0);
    wait_c(9);
    chk("e_spr_idle2", {16'd0, b, nboe}, {16'd0, 15'h0, 1'b1});
    wait_c(12);
    chk("e_cpu_read", {15'd0, b, nboe, e_oe}, {15'd0, 15'h2345, 1'b0, 1'b0});
    wait_c(15);
    spr_en = 1'b1;

    // Period F: write aborted by SYNC_LOAD at C=13, retried in period G.
    push_map_reads();
    push_map_reads();
    push(KWr, 15, 15'h0DDD, 16'h4444);
    wait_c(2);
    request(15'h0DDD, 16'h4444);
    wait_c(3);
    nreq = 1'b1;
    wait_c(13);
    chk("f_c13_nbwe", {31'd0, nbwe}, 32'd0);
    sync_load = 1'b1;
    tick();
    sync_load = 1'b0;
    chk("abort_ctl", {28'd0, nbwe, wr_done, wr_pending, e_oe}, {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    chk("abort_slot0_b", {17'd0, b}, 32'h0122);
    wait_c(15);
    wait_c(1);
    chk("g_pending_clear", {31'd0, wr_pending}, 32'd0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slow_vram_sched.md
# slow_vram_sched

Slot scheduler for the 32K×16 slow VRAM (120 ns, at least 3 mclk access). Divides each 16-mclk LSPC 1.5 MHz period into four fixed 4-mclk slots: sprite map even, fix map, sprite map odd, and CPU. It drives the shared address bus, the active-low output and write enables, and the data bus output enable. It also generates one-cycle latch strobes for the downstream map and CPU read registers, and queues a single CPU write request until the next CPU slot.

## Interface
Parameters: none.

- CLK_24M  in  1  master clock; all state changes on rising edge
- RESETP  in  1  synchronous, active-high reset
- SYNC_LOAD  in  1  slot-counter realign; high → counter loads 0 on next edge
- SPR_EN  in  1  high: sprite slots read the sprite map; low: sprite slots idle
- FIXMAP_ADDR  in  15  fix map word address
- SPRMAP_ADDR  in  15  sprite map word address; bit 0 is forced 0 in the even slot and 1 in the odd slot
- VRAM_ADDR  in  15  CPU VRAM address
- VRAM_WRITE  in  16  CPU write data
- nVRAM_WRITE_REQ  in  1  CPU write request, active low; a falling edge is a request
- REG_VRAMADDR_MSB  in  1  high: address targets fast VRAM, request ignored
- B  out  15  slow VRAM address
- E_OUT  out  16  write data to the E bus
- E_OE  out  1  E bus driver enable
- nBOE  out  1  VRAM output enable, active low
- nBWE  out  1  VRAM write enable, active low
- LATCH_SPR_EVEN, LATCH_FIX, LATCH_SPR_ODD, LATCH_CPU  out  1 each  one-cycle read-capture strobes
- WR_PENDING  out  1  a CPU write is queued or in progress
- WR_DONE  out  1  one-cycle pulse; a write has completed

## Operation
- **Slot counter.** A 4-bit counter C increments every CLK_24M and wraps 15→0.
  - Slot S = C[3:2]; phase P = C[1:0].
  - Slot 0: sprite even. Slot 1: fix. Slot 2: sprite odd. Slot 3: CPU.
- **Read slots.** B holds the slot address for all 4 phases. nBOE = 0 for phases 0–3. The slot's strobe is high at P = 3.
- **Sprite slots with SPR_EN = 0.** B = 0, nBOE = 1, no strobe.
- **Write capture.**
  - Register the previous value of nVRAM_WRITE_REQ. A request is (prev = 1) & (now = 0) & (REG_VRAMADDR_MSB = 0).
  - On a request, latch VRAM_ADDR and VRAM_WRITE into hold registers and set WR_PENDING.
  - A request while already pending overwrites the hold registers (last wins) and is still serviced exactly once.
- **CPU slot decision.** Taken when C becomes 12: wr_active = WR_PENDING. It is fixed for the whole slot.
  - **Write (wr_active = 1).**
    - B = held address for the whole slot.
    - nBOE = 1 for the whole slot.
    - E_OE = 1 at P = 0..3.
    - nBWE = 0 at P = 1..2 only.
    - E_OUT = held data.
    - WR_DONE = 1 at C = 15.
    - WR_PENDING clears on the edge leaving C = 15. If a new request is captured on that same edge, WR_PENDING stays 1 with the new data.
  - **Read (wr_active = 0).** B = VRAM_ADDR, nBOE = 0, LATCH_CPU = 1 at C = 15.
- **SYNC_LOAD.** C loads 0. A slot in progress is abandoned with no strobe and no WR_DONE. An aborted write leaves WR_PENDING = 1 and is retried in the next CPU slot.
- **Invariants.**
  - nBWE = 0 never coincides with nBOE = 0.
  - E_OE = 0 whenever nBOE = 0.

## Timing
- Outputs are registered. Each is computed from the next value of C and the state, so it is stable for the entire cycle in which the counter holds C.
- Reset state:
  - C = 0, WR_PENDING = 0, wr_active = 0.
  - B = 0, E_OUT = 0, E_OE = 0, nBOE = 1, nBWE = 1.
  - All strobes = 0, WR_DONE = 0.
  - Stored prev-request = 1, so a request low through reset is not taken as an edge.
- The first cycle after RESETP deasserts has C = 0: slot 0, nBOE = 0 if SPR_EN = 1.
- Read data is valid 3 mclk after the address. The strobe at P = 3 is one cycle before the slot change; the downstream register samples on the next edge.
- Write latency: from the request edge to WR_DONE is 4–19 cycles, depending on slot position. A request captured at C = 12 or later waits for the next period.
- RESETP has priority over SYNC_LOAD. SYNC_LOAD has priority over increment.

## Test plan
- **Reset.** Hold RESETP 3 cycles with nVRAM_WRITE_REQ = 0 → all outputs at their reset values, WR_PENDING = 0. After release, nBOE = 0 at C = 0.
- **Read sweep.** SPR_EN = 1, FIXMAP_ADDR = 0x7005, SPRMAP_ADDR = 0x0123, VRAM_ADDR = 0x4000 → across one 16-cycle period:
  - B = 0x0122, 0x7005, 0x0123, 0x4000.
  - LATCH strobes fire only at C = 3, 7, 11, 15.
- **Single write.** Request at C = 2, address 0x1234, data 0xBEEF → at C = 12..15: B = 0x1234, E_OE = 1, nBWE = 0 only at C = 13–14, WR_DONE at C = 15, then WR_PENDING = 0.
- **Overwrite and boundary capture.**
  - Two requests before a CPU slot (data 0x1111 then 0x2222) → exactly one write, of 0x2222.
  - A request captured on the C = 15 → 0 edge → WR_PENDING stays 1, and the second write occurs in the next period.
- **Fast-VRAM filter and SPR_EN.**
  - Request with REG_VRAMADDR_MSB = 1 → no pending, the CPU slot performs a read.
  - SPR_EN = 0 → slots 0 and 2 give B = 0, nBOE = 1, no strobes.
- **SYNC_LOAD abort.** Assert at C = 13 during a write → next cycle C = 0, nBWE = 1, no WR_DONE, WR_PENDING = 1. The write completes at the following C = 15.
